// File: rtl/debounce_edge_array.sv
// Multi-channel input conditioner: synchroniser, stable-count debouncer,
// rise/fall pulse generation and sticky event flags with write-1-to-clear.
module debounce_edge_array #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CH-1:0] sig_in,
  input  logic [CH-1:0] rise_en,
  input  logic [CH-1:0] fall_en,
  input  logic [CH-1:0] clr,
  output logic [CH-1:0] level,
  output logic [CH-1:0] pos_edge,
  output logic [CH-1:0] neg_edge,
  output logic [CH-1:0] evt,
  output logic [CH-1:0] sticky,
  output logic          any_evt
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CH-1:0]    sync_r [SYNC_STAGES];
  logic [CNT_W-1:0] cnt    [CH];
  logic [CNT_W-1:0] cnt_nx [CH];
  logic [CH-1:0]    sync_q;
  logic [CH-1:0]    level_nx;
  logic [CH-1:0]    pos_nx;
  logic [CH-1:0]    neg_nx;
  logic [CH-1:0]    evt_nx;

  assign sync_q = sync_r[SYNC_STAGES-1];

  // Per-channel debounce: a new level is accepted after DB_CYCLES
  // consecutive mismatching synchronised samples.
  always_comb begin
    level_nx = level;
    pos_nx   = '0;
    neg_nx   = '0;
    for (int i = 0; i < int'(CH); i++) begin
      cnt_nx[i] = '0;
      if (sync_q[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_nx[i] = sync_q[i];
          pos_nx[i]   = sync_q[i];
          neg_nx[i]   = ~sync_q[i];
        end else begin
          cnt_nx[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
    evt_nx = (pos_nx & rise_en) | (neg_nx & fall_en);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_r[k] <= '0;
      for (int i = 0; i < int'(CH); i++) cnt[i] <= '0;
      level    <= '0;
      pos_edge <= '0;
      neg_edge <= '0;
      evt      <= '0;
      sticky   <= '0;
    end else begin
      sync_r[0] <= sig_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_r[k] <= sync_r[k-1];
      for (int i = 0; i < int'(CH); i++) cnt[i] <= cnt_nx[i];
      level    <= level_nx;
      pos_edge <= pos_nx;
      neg_edge <= neg_nx;
      evt      <= evt_nx;
      // A new event on the same edge as a clear keeps the flag set.
      sticky   <= (sticky & ~clr) | evt_nx;
    end
  end

  assign any_evt = |sticky;

endmodule
